// File: rtl/vmu_mem_arb.sv
// vmu_mem_arb: arbitrates the vector load and store engines onto a single
// registered cache request slot. Round-robin on ties (load wins the first
// tie after reset), load credits bounded by MAX_OUTSTANDING.
// Optional build macro: VMU_ARB_HAZARD_CHECK_EN enables the load/store
// address-range hazard block on loads; without it loads are gated only by
// credits.
module vmu_mem_arb #(
    parameter int ADDR_WIDTH      = 32,
    parameter int REQ_DATA_WIDTH  = 256,
    parameter int TICKET_WIDTH    = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    // load engine
    input  logic                              ld_req_i,
    input  logic [ADDR_WIDTH-1:0]             ld_addr_i,
    input  logic [TICKET_WIDTH-1:0]           ld_ticket_i,
    output logic                              ld_grant_o,
    // store engine
    input  logic                              st_req_i,
    input  logic [ADDR_WIDTH-1:0]             st_addr_i,
    input  logic [REQ_DATA_WIDTH-1:0]         st_data_i,
    output logic                              st_grant_o,
    // engine sync ranges (inclusive)
    input  logic                              st_busy_i,
    input  logic [ADDR_WIDTH-1:0]             st_start_addr_i,
    input  logic [ADDR_WIDTH-1:0]             st_end_addr_i,
    input  logic [ADDR_WIDTH-1:0]             ld_start_addr_i,
    input  logic [ADDR_WIDTH-1:0]             ld_end_addr_i,
    // cache request
    output logic                              mem_req_valid_o,
    output logic [ADDR_WIDTH-1:0]             mem_req_addr_o,
    output logic                              mem_req_is_store_o,
    output logic [TICKET_WIDTH-1:0]           mem_req_ticket_o,
    output logic [REQ_DATA_WIDTH-1:0]         mem_req_data_o,
    input  logic                              cache_ready_i,
    // load responses
    input  logic                              mem_resp_valid_i,
    // status
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
    output logic                              idle_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W:0]   MAX_INFLIGHT = (CNT_W + 1)'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] MAX_CNT      = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_t;

    slot_state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic                       is_store_q, is_store_d;
    logic [TICKET_WIDTH-1:0]    ticket_q, ticket_d;
    logic [REQ_DATA_WIDTH-1:0]  data_q, data_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       last_st_q, last_st_d;   // 1: store won last grant

    logic                       can_accept;
    logic                       slot_ld;
    logic [CNT_W:0]             inflight;
    logic                       hazard;
    logic                       ld_elig;
    logic                       st_elig;
    logic                       ld_win;
    logic                       st_win;
    logic                       ld_hs;
    logic                       rsp_dec;

`ifdef VMU_ARB_HAZARD_CHECK_EN
    logic                       range_ovl;
    logic                       slot_st_hit;

    // Load is blocked while a busy store range overlaps it, or the slot
    // still holds a store inside the load range.
    always_comb begin
        range_ovl   = st_busy_i
                      && (ld_start_addr_i <= st_end_addr_i)
                      && (st_start_addr_i <= ld_end_addr_i);
        slot_st_hit = (state_q == S_FULL) && is_store_q
                      && (addr_q >= ld_start_addr_i)
                      && (addr_q <= ld_end_addr_i);
        hazard      = range_ovl || slot_st_hit;
    end
`else
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = ^{st_busy_i, st_start_addr_i, st_end_addr_i,
                                    ld_start_addr_i, ld_end_addr_i};

    // No hazard term in this build: loads are gated only by credits.
    always_comb begin
        hazard = 1'b0;
    end
`endif

    // Eligibility and round-robin winner selection; grants are combinational
    // in the accept cycle and suppressed while reset is asserted.
    always_comb begin
        can_accept = (state_q == S_EMPTY) || cache_ready_i;
        slot_ld    = (state_q == S_FULL) && !is_store_q;
        // credits count the load parked in the slot as already in flight
        inflight   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, slot_ld};
        ld_elig    = ld_req_i && (inflight < MAX_INFLIGHT) && !hazard;
        st_elig    = st_req_i;
        ld_win     = 1'b0;
        st_win     = 1'b0;
        if (rst_n && can_accept) begin
            if (ld_elig && st_elig) begin
                ld_win = last_st_q;
                st_win = !last_st_q;
            end else begin
                ld_win = ld_elig;
                st_win = st_elig;
            end
        end
    end

    // Next slot contents, arbitration history and load credit counter.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        is_store_d = is_store_q;
        ticket_d   = ticket_q;
        data_d     = data_q;
        last_st_d  = last_st_q;
        cnt_d      = cnt_q;

        if (ld_win) begin
            state_d    = S_FULL;
            addr_d     = ld_addr_i;
            is_store_d = 1'b0;
            ticket_d   = ld_ticket_i;
            data_d     = '0;
            last_st_d  = 1'b0;
        end else if (st_win) begin
            state_d    = S_FULL;
            addr_d     = st_addr_i;
            is_store_d = 1'b1;
            ticket_d   = '0;
            data_d     = st_data_i;
            last_st_d  = 1'b1;
        end else if ((state_q == S_FULL) && cache_ready_i) begin
            // drained with nothing to refill: clear so the idle bus reads 0
            state_d    = S_EMPTY;
            addr_d     = '0;
            is_store_d = 1'b0;
            ticket_d   = '0;
            data_d     = '0;
        end

        ld_hs   = (state_q == S_FULL) && cache_ready_i && !is_store_q;
        rsp_dec = mem_resp_valid_i && (cnt_q != '0);
        if (ld_hs && !rsp_dec && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (rsp_dec && !ld_hs) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State registers; reset discards any in-flight slot content.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            addr_q     <= '0;
            is_store_q <= 1'b0;
            ticket_q   <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            last_st_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            is_store_q <= is_store_d;
            ticket_q   <= ticket_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            last_st_q  <= last_st_d;
        end
    end

    assign ld_grant_o         = ld_win;
    assign st_grant_o         = st_win;
    assign mem_req_valid_o    = (state_q == S_FULL);
    assign mem_req_addr_o     = addr_q;
    assign mem_req_is_store_o = is_store_q;
    assign mem_req_ticket_o   = ticket_q;
    assign mem_req_data_o     = data_q;
    assign outstanding_o      = cnt_q;
    assign idle_o             = (state_q == S_EMPTY) && (cnt_q == '0);

endmodule

// File: tb/tb_vmu_mem_arb.sv
// Testbench for vmu_mem_arb: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a behavioural model of the slot,
// credit count and round-robin history.
module tb_vmu_mem_arb;

    localparam int AW  = 32;
    localparam int DW  = 256;
    localparam int TW  = 4;
    localparam int MAX = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ld_req_i;
    logic [AW-1:0]  ld_addr_i;
    logic [TW-1:0]  ld_ticket_i;
    logic           ld_grant_o;
    logic           st_req_i;
    logic [AW-1:0]  st_addr_i;
    logic [DW-1:0]  st_data_i;
    logic           st_grant_o;
    logic           st_busy_i;
    logic [AW-1:0]  st_start_addr_i, st_end_addr_i;
    logic [AW-1:0]  ld_start_addr_i, ld_end_addr_i;
    logic           mem_req_valid_o;
    logic [AW-1:0]  mem_req_addr_o;
    logic           mem_req_is_store_o;
    logic [TW-1:0]  mem_req_ticket_o;
    logic [DW-1:0]  mem_req_data_o;
    logic           cache_ready_i;
    logic           mem_resp_valid_i;
    logic [3:0]     outstanding_o;
    logic           idle_o;

    vmu_mem_arb #(
        .ADDR_WIDTH(AW), .REQ_DATA_WIDTH(DW), .TICKET_WIDTH(TW), .MAX_OUTSTANDING(MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_ticket_i(ld_ticket_i),
        .ld_grant_o(ld_grant_o),
        .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
        .st_grant_o(st_grant_o),
        .st_busy_i(st_busy_i), .st_start_addr_i(st_start_addr_i),
        .st_end_addr_i(st_end_addr_i), .ld_start_addr_i(ld_start_addr_i),
        .ld_end_addr_i(ld_end_addr_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_is_store_o(mem_req_is_store_o), .mem_req_ticket_o(mem_req_ticket_o),
        .mem_req_data_o(mem_req_data_o), .cache_ready_i(cache_ready_i),
        .mem_resp_valid_i(mem_resp_valid_i),
        .outstanding_o(outstanding_o), .idle_o(idle_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // behavioural model: one request slot, loads in flight, last winner
    bit             m_full;
    logic [AW-1:0]  m_addr;
    bit             m_st;
    logic [TW-1:0]  m_tkt;
    logic [DW-1:0]  m_data;
    int             m_out;
    bit             m_last_st;

    // grants observed by the most recent step
    logic           obs_lg, obs_sg, obs_valid;

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        m_full = 0; m_addr = '0; m_st = 0; m_tkt = '0; m_data = '0;
        m_out = 0; m_last_st = 1;
    endtask

    // One clock: compare DUT against model at negedge, advance model, then
    // return just after the next rising edge so callers may drive inputs.
    task automatic step();
        bit can, le, se, haz, exp_lg, exp_sg, hs_ld, dec;
        int inflight;
        @(negedge clk);
        can      = !m_full || cache_ready_i;
        inflight = m_out + ((m_full && !m_st) ? 1 : 0);
        haz      = 0;
`ifdef VMU_ARB_HAZARD_CHECK_EN
        if (st_busy_i && !(ld_end_addr_i < st_start_addr_i || st_end_addr_i < ld_start_addr_i))
            haz = 1;
        if (m_full && m_st && m_addr >= ld_start_addr_i && m_addr <= ld_end_addr_i)
            haz = 1;
`endif
        le = ld_req_i && (inflight < MAX) && !haz;
        se = st_req_i;
        exp_lg = 0; exp_sg = 0;
        if (rst_n && can) begin
            if (le && se) begin
                exp_lg = m_last_st; exp_sg = !m_last_st;
            end else begin
                exp_lg = le; exp_sg = se;
            end
        end
        obs_lg = ld_grant_o; obs_sg = st_grant_o; obs_valid = mem_req_valid_o;

        n_cmp++;
        if ({ld_grant_o, st_grant_o} !== {exp_lg, exp_sg}) begin
            n_fail++;
            $display("FAIL grant @%0t: got ld=%b st=%b expected ld=%b st=%b",
                     $time, ld_grant_o, st_grant_o, exp_lg, exp_sg);
        end
        n_cmp++;
        if ({mem_req_valid_o, mem_req_addr_o, mem_req_is_store_o, mem_req_ticket_o}
            !== {m_full, m_addr, m_st, m_tkt}) begin
            n_fail++;
            $display("FAIL slot @%0t: got v=%b a=%h s=%b t=%h expected v=%b a=%h s=%b t=%h",
                     $time, mem_req_valid_o, mem_req_addr_o, mem_req_is_store_o,
                     mem_req_ticket_o, m_full, m_addr, m_st, m_tkt);
        end
        n_cmp++;
        if (mem_req_data_o !== m_data) begin
            n_fail++;
            $display("FAIL slot_data @%0t: got %h expected %h", $time, mem_req_data_o, m_data);
        end
        n_cmp++;
        if ({outstanding_o, idle_o} !== {m_out[3:0], (!m_full && m_out == 0)}) begin
            n_fail++;
            $display("FAIL status @%0t: got out=%0d idle=%b expected out=%0d idle=%b",
                     $time, outstanding_o, idle_o, m_out, (!m_full && m_out == 0));
        end

        if (!rst_n) begin
            model_reset();
        end else begin
            hs_ld = m_full && cache_ready_i && !m_st;
            dec   = mem_resp_valid_i && m_out > 0;
            m_out = m_out + (hs_ld ? 1 : 0) - (dec ? 1 : 0);
            if (exp_lg) begin
                m_full = 1; m_addr = ld_addr_i; m_st = 0; m_tkt = ld_ticket_i;
                m_data = '0; m_last_st = 0;
            end else if (exp_sg) begin
                m_full = 1; m_addr = st_addr_i; m_st = 1; m_tkt = '0;
                m_data = st_data_i; m_last_st = 1;
            end else if (m_full && cache_ready_i) begin
                m_full = 0; m_addr = '0; m_st = 0; m_tkt = '0; m_data = '0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_req_i = 0; st_req_i = 0; cache_ready_i = 1; mem_resp_valid_i = 0;
        st_busy_i = 0;
        st_start_addr_i = '0; st_end_addr_i = '0;
        ld_start_addr_i = 32'hFFFF_0000; ld_end_addr_i = 32'hFFFF_00FF;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        ld_req_i = 1; st_req_i = 1;
        ld_addr_i = 32'h40; st_addr_i = 32'h80; st_data_i = rand_data();
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        step();
        n_cmp++;
        if ({obs_lg, obs_sg, idle_o} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_grants: got ld=%b st=%b idle=%b expected 0 0 1",
                     obs_lg, obs_sg, idle_o);
        end
        rst_n = 1; ld_req_i = 0; st_req_i = 0;
        mem_resp_valid_i = 1;
        step();
        mem_resp_valid_i = 0;
        n_cmp++;
        if (outstanding_o !== 4'd0) begin
            n_fail++;
            $display("FAIL resp_at_zero: got %0d expected 0", outstanding_o);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        ld_req_i = 1; st_req_i = 1; cache_ready_i = 1;
        for (int i = 0; i < 6; i++) begin
            ld_addr_i = 32'h1000 + 32'(i); ld_ticket_i = 4'(i);
            st_addr_i = 32'h2000 + 32'(i); st_data_i = rand_data();
            step();
            n_cmp++;
            if ({obs_lg, obs_sg, obs_valid} !== {(i % 2 == 0), (i % 2 == 1), (i >= 1)}) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: got ld=%b st=%b v=%b expected ld=%b st=%b v=%b",
                         i, obs_lg, obs_sg, obs_valid, (i % 2 == 0), (i % 2 == 1), (i >= 1));
            end
        end
        ld_req_i = 0; st_req_i = 0;
        step();
    endtask

    task automatic test_credits();
        int granted = 0;
        do_reset();
        ld_req_i = 1; cache_ready_i = 1;
        for (int i = 0; i < 20 && granted < 8; i++) begin
            ld_addr_i = $urandom; ld_ticket_i = 4'($urandom);
            step();
            if (obs_lg) granted++;
        end
        n_cmp++;
        if (granted != 8) begin
            n_fail++;
            $display("FAIL credits_grant8: got %0d expected 8 within budget", granted);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (obs_lg !== 1'b0) begin
                n_fail++;
                $display("FAIL credits_block[%0d]: got grant=%b expected 0", i, obs_lg);
            end
        end
        n_cmp++;
        if (outstanding_o !== 4'd8) begin
            n_fail++;
            $display("FAIL credits_out8: got %0d expected 8", outstanding_o);
        end
        mem_resp_valid_i = 1;
        step();
        mem_resp_valid_i = 0;
        step();
        n_cmp++;
        if (obs_lg !== 1'b1) begin
            n_fail++;
            $display("FAIL credits_ninth: got grant=%b expected 1", obs_lg);
        end
        ld_req_i = 0;
        for (int i = 0; i < 8; i++) begin
            mem_resp_valid_i = 1;
            step();
        end
        mem_resp_valid_i = 0;
    endtask

    task automatic test_stall();
        logic [DW-1:0] d0;
        do_reset();
        d0 = rand_data();
        st_req_i = 1; st_addr_i = 32'h100; st_data_i = d0; cache_ready_i = 0;
        step();
        st_addr_i = 32'h200; st_data_i = rand_data();
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if ({obs_lg, obs_sg, mem_req_valid_o, mem_req_addr_o, mem_req_is_store_o,
                 mem_req_data_o} !== {2'b00, 1'b1, 32'h100, 1'b1, d0}) begin
                n_fail++;
                $display("FAIL stall[%0d]: got g=%b%b v=%b a=%h s=%b expected g=00 v=1 a=100 s=1",
                         i, obs_lg, obs_sg, mem_req_valid_o, mem_req_addr_o, mem_req_is_store_o);
            end
        end
        cache_ready_i = 1;
        step();
        n_cmp++;
        if ({obs_sg, mem_req_addr_o} !== {1'b1, 32'h200}) begin
            n_fail++;
            $display("FAIL stall_refill: got st_grant=%b addr=%h expected 1 200",
                     obs_sg, mem_req_addr_o);
        end
        st_req_i = 0;
        step();
    endtask

    task automatic test_same_cycle();
        do_reset();
        ld_req_i = 1; cache_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            ld_addr_i = 32'h300 + 32'(i); ld_ticket_i = 4'(i);
            step();
        end
        ld_req_i = 0;
        step();
        ld_req_i = 1; cache_ready_i = 0; ld_ticket_i = 4'hA;
        step();
        ld_req_i = 0; cache_ready_i = 1; mem_resp_valid_i = 1;
        n_cmp++;
        if (outstanding_o !== 4'd3) begin
            n_fail++;
            $display("FAIL same_cycle_pre: got %0d expected 3", outstanding_o);
        end
        step();
        mem_resp_valid_i = 0;
        n_cmp++;
        if (outstanding_o !== 4'd3) begin
            n_fail++;
            $display("FAIL same_cycle: got %0d expected 3", outstanding_o);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        st_busy_i = 1;
        st_start_addr_i = 32'h1000; st_end_addr_i = 32'h101F;
        ld_start_addr_i = 32'h1010; ld_end_addr_i = 32'h102F;
        ld_req_i = 1; ld_addr_i = 32'h1010; ld_ticket_i = 4'h5; cache_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
`ifdef VMU_ARB_HAZARD_CHECK_EN
            if (obs_lg !== 1'b0) begin
                n_fail++;
                $display("FAIL hazard_block[%0d]: got grant=%b expected 0", i, obs_lg);
            end
`else
            if (obs_lg !== 1'b1) begin
                n_fail++;
                $display("FAIL hazard_none[%0d]: got grant=%b expected 1", i, obs_lg);
            end
`endif
        end
        st_busy_i = 0;
        step();
        n_cmp++;
        if (obs_lg !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_release: got grant=%b expected 1", obs_lg);
        end
        ld_req_i = 0;
        do_reset();
    endtask

    task automatic test_reset_mid();
        do_reset();
        ld_req_i = 1; cache_ready_i = 1;
        for (int i = 0; i < 5; i++) begin
            ld_addr_i = 32'h500 + 32'(i); ld_ticket_i = 4'(i);
            step();
        end
        ld_req_i = 0; st_req_i = 1; st_addr_i = 32'h600; st_data_i = rand_data();
        step();
        st_req_i = 0; cache_ready_i = 0;
        n_cmp++;
        if ({mem_req_valid_o, outstanding_o} !== {1'b1, 4'd5}) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got v=%b out=%0d expected v=1 out=5",
                     mem_req_valid_o, outstanding_o);
        end
        rst_n = 0; ld_req_i = 1; st_req_i = 1;
        step();
        n_cmp++;
        if ({obs_lg, obs_sg, mem_req_valid_o, mem_req_addr_o, mem_req_is_store_o,
             mem_req_ticket_o, outstanding_o, idle_o}
            !== {2'b00, 1'b0, 32'h0, 1'b0, 4'h0, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid: got g=%b%b v=%b a=%h s=%b t=%h out=%0d idle=%b expected all 0 idle=1",
                     obs_lg, obs_sg, mem_req_valid_o, mem_req_addr_o, mem_req_is_store_o,
                     mem_req_ticket_o, outstanding_o, idle_o);
        end
        rst_n = 1; ld_req_i = 0; st_req_i = 0;
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ld_req_i         = ($urandom_range(0, 3) != 0);
            st_req_i         = ($urandom_range(0, 2) == 0);
            cache_ready_i    = ($urandom_range(0, 3) != 0);
            mem_resp_valid_i = (m_out > 0) && ($urandom_range(0, 2) == 0);
            ld_addr_i        = 32'($urandom_range(0, 255));
            ld_ticket_i      = 4'($urandom);
            st_addr_i        = 32'($urandom_range(0, 255));
            st_data_i        = rand_data();
            st_busy_i        = ($urandom_range(0, 3) == 0);
            st_start_addr_i  = 32'($urandom_range(0, 223));
            st_end_addr_i    = st_start_addr_i + 32'($urandom_range(0, 31));
            ld_start_addr_i  = 32'($urandom_range(0, 223));
            ld_end_addr_i    = ld_start_addr_i + 32'($urandom_range(0, 31));
            if ($urandom_range(0, 99) == 0) rst_n = 0;
            step();
            rst_n = 1;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_credits();
        test_stall();
        test_same_cycle();
        test_hazard();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
